// File: rtl/pe_reducer.sv
`default_nettype none
// ============================================================================
// pe_reducer : 3-lane signed MAC with reduce-then-scatter into a 3-bank buffer
// Rev 1.0
// ============================================================================
module pe_reducer #(
  parameter int LANES      = 3,
  parameter int DATA_W     = 16,
  parameter int IA_CHANNEL = 64,
  parameter int ACC_W      = 32,
  parameter int ADDR_W     = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [2:0][ADDR_W-1:0]   i_addr [0:LANES-1],
  input  logic signed [DATA_W-1:0] i_w    [0:LANES-1],
  input  logic signed [DATA_W-1:0] i_ia   [0:LANES-1],
  output logic signed [ACC_W-1:0]  o_buf  [0:3*IA_CHANNEL-1],
  output logic                     o_finish
);

  localparam int BANKS = 3;
  localparam int DEPTH = BANKS * IA_CHANNEL;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0][ADDR_W-1:0]     r_addr [0:LANES-1];
  logic signed [DATA_W-1:0]   r_w    [0:LANES-1];
  logic signed [DATA_W-1:0]   r_ia   [0:LANES-1];
  logic signed [ACC_W-1:0]    r_prod [0:LANES-1];

  logic signed [2*DATA_W-1:0] w_prod_full [0:LANES-1];
  logic                       w_hit [0:BANKS-1][0:LANES-1];
  logic [IDX_W-1:0]           w_idx [0:BANKS-1][0:LANES-1];
  logic signed [ACC_W-1:0]    w_red [0:BANKS-1][0:LANES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CAP;
      S_CAP:   w_next = S_ACC;
      S_ACC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are captured only on the accepted start edge, so later input
  // changes cannot disturb an operation already in flight.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (r_state == S_IDLE && i_start) begin
        r_addr[i] <= i_addr[i];
        r_w[i]    <= i_w[i];
        r_ia[i]   <= i_ia[i];
      end
      if (r_state == S_CAP) r_prod[i] <= ACC_W'(w_prod_full[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod_full[i] = r_w[i] * r_ia[i];
    end
  end

  // Every lane carries the total of all lanes aimed at its entry, so duplicate
  // writes to one entry all store the same reduced value.
  always_comb begin
    for (int k = 0; k < BANKS; k++) begin
      for (int i = 0; i < LANES; i++) begin
        w_hit[k][i] = (r_addr[i][k] < ADDR_W'(IA_CHANNEL));
        w_idx[k][i] = IDX_W'(k * IA_CHANNEL) + IDX_W'(r_addr[i][k]);
        w_red[k][i] = '0;
        for (int j = 0; j < LANES; j++) begin
          if (r_addr[j][k] == r_addr[i][k]) w_red[k][i] = w_red[k][i] + r_prod[j];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_finish <= 1'b0;
      for (int d = 0; d < DEPTH; d++) o_buf[d] <= '0;
    end else begin
      o_finish <= (r_state == S_ACC);
      if (r_state == S_ACC) begin
        for (int k = 0; k < BANKS; k++) begin
          for (int i = 0; i < LANES; i++) begin
            if (w_hit[k][i]) o_buf[w_idx[k][i]] <= o_buf[w_idx[k][i]] + w_red[k][i];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_reducer.sv
`default_nettype none
// ============================================================================
// tb_pe_reducer : directed scoreboard bench for pe_reducer
// Rev 1.0
// ============================================================================
module tb_pe_reducer;

  localparam int LANES = 3;
  localparam int DW    = 16;
  localparam int C     = 64;
  localparam int AW    = 32;
  localparam int ADW   = 7;
  localparam int DEPTH = 3 * C;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [2:0][ADW-1:0]  addr [0:LANES-1];
  logic signed [DW-1:0] w    [0:LANES-1];
  logic signed [DW-1:0] ia   [0:LANES-1];
  logic signed [AW-1:0] obuf [0:DEPTH-1];
  logic                 finish;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_finish = 0;

  typedef struct {
    int                   idx;
    logic signed [AW-1:0] val;
    bit                   last;
  } exp_t;
  exp_t q[$];

  pe_reducer #(.LANES(LANES), .DATA_W(DW), .IA_CHANNEL(C), .ACC_W(AW), .ADDR_W(ADW)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_addr   (addr),
    .i_w      (w),
    .i_ia     (ia),
    .o_buf    (obuf),
    .o_finish (finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [AW-1:0] act,
                       input logic signed [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic signed [AW-1:0] val, input bit last);
    exp_t e;
    e.idx  = idx;
    e.val  = val;
    e.last = last;
    q.push_back(e);
  endtask

  task automatic set_lane(input int i, input int a0, input int a1, input int a2,
                          input int wv, input int iav);
    addr[i][0] = ADW'(a0);
    addr[i][1] = ADW'(a1);
    addr[i][2] = ADW'(a2);
    w[i]       = DW'(wv);
    ia[i]      = DW'(iav);
  endtask

  task automatic scramble();
    for (int i = 0; i < LANES; i++) set_lane(i, 0, 0, 0, 100, 100);
  endtask

  function automatic int nonzero();
    int n = 0;
    for (int d = 0; d < DEPTH; d++) if (obuf[d] !== '0) n++;
    return n;
  endfunction

  // Issue one op, clobber the inputs right after the start edge, then allow
  // the monitor a bounded window to retire the expectations.
  task automatic run_op(input string name);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    check({name, "_drain"}, AW'(q.size()), 0);
  endtask

  // Monitor: every finish pulse retires one op's worth of expectations.
  always @(negedge clk) begin
    exp_t e;
    bit   done;
    if (finish === 1'b1) begin
      n_finish++;
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_finish: got finish=1 with no op pending, expected 0");
      end else begin
        done = 1'b0;
        while (!done && q.size() > 0) begin
          e = q.pop_front();
          check($sformatf("buf[%0d]", e.idx), obuf[e.idx], e.val);
          done = e.last;
        end
      end
    end
  end

  initial begin
    scramble();

    // Reset, then idle with start low.
    repeat (2) @(negedge clk);
    check("reset_finish", AW'(finish), 0);
    check("reset_nonzero", AW'(nonzero()), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_finish", AW'(finish), 0);
    check("idle_nonzero", AW'(nonzero()), 0);

    // Distinct addresses.
    set_lane(0, 0, 0, 0, 15, 3);
    set_lane(1, 1, 1, 1, 16, 2);
    set_lane(2, 2, 2, 2, 17, 1);
    for (int k = 0; k < 3; k++) begin
      push_exp(k*C + 0, 45, 1'b0);
      push_exp(k*C + 1, 32, 1'b0);
      push_exp(k*C + 2, 17, k == 2);
    end
    run_op("op1");

    // Two lanes collide on entry 2; accumulates onto prior contents.
    set_lane(0, 2, 2, 2, 4, 3);
    set_lane(1, 2, 2, 2, 5, 2);
    set_lane(2, 3, 3, 3, 6, 1);
    for (int k = 0; k < 3; k++) begin
      push_exp(k*C + 2, 39, 1'b0);
      push_exp(k*C + 3, 6, 1'b0);
      push_exp(k*C + 0, 45, 1'b0);
      push_exp(k*C + 1, 32, k == 2);
    end
    run_op("op2");

    // Signed products at the operand extremes.
    set_lane(0, 10, 10, 10, -32768, -32768);
    set_lane(1, 11, 11, 11, -5, 7);
    set_lane(2, 12, 12, 12, 32767, -32768);
    for (int k = 0; k < 3; k++) begin
      push_exp(k*C + 10, 1073741824, 1'b0);
      push_exp(k*C + 11, -35, 1'b0);
      push_exp(k*C + 12, -1073709056, k == 2);
    end
    run_op("op3");

    // Reduced sum 2^31 wraps to the most negative value.
    set_lane(0, 20, 20, 20, -32768, -32768);
    set_lane(1, 20, 20, 20, -32768, -32768);
    set_lane(2, 21, 21, 21, 1, 1);
    for (int k = 0; k < 3; k++) begin
      push_exp(k*C + 20, 32'sh8000_0000, 1'b0);
      push_exp(k*C + 21, 1, k == 2);
    end
    run_op("op4");

    // Out-of-range fields (100) dropped per bank; start held while busy.
    set_lane(0, 100, 30, 30, 2, 3);
    set_lane(1, 31, 100, 31, 1, 1);
    set_lane(2, 32, 32, 100, 1, 4);
    push_exp(0*C + 30, 0, 1'b0);
    push_exp(0*C + 31, 1, 1'b0);
    push_exp(0*C + 32, 4, 1'b0);
    push_exp(1*C + 30, 6, 1'b0);
    push_exp(1*C + 31, 0, 1'b0);
    push_exp(1*C + 32, 4, 1'b0);
    push_exp(2*C + 30, 6, 1'b0);
    push_exp(2*C + 31, 1, 1'b0);
    push_exp(2*C + 32, 0, 1'b0);
    push_exp(100, 0, 1'b1);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LANES; i++) set_lane(i, 40, 40, 40, 1, 1);
    @(negedge clk);
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    check("op5_drain", AW'(q.size()), 0);
    check("busy_start_b0", obuf[0*C + 40], 0);
    check("busy_start_b1", obuf[1*C + 40], 0);
    check("busy_start_b2", obuf[2*C + 40], 0);
    check("finish_count_5", AW'(n_finish), 5);

    // Reset lands on the CAP->ACC edge.
    for (int i = 0; i < LANES; i++) set_lane(i, 1, 1, 1, 1, 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin
      start = 1'b0;
      rst_n = 1'b0;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midop_reset_nonzero", AW'(nonzero()), 0);
    check("midop_reset_finish", AW'(n_finish), 5);

    // FSM usable again; top valid index 63 with a colliding pair.
    set_lane(0, 5, 5, 5, 2, 2);
    set_lane(1, 63, 63, 63, 1, -1);
    set_lane(2, 63, 63, 63, 3, 1);
    for (int k = 0; k < 3; k++) begin
      push_exp(k*C + 5, 4, 1'b0);
      push_exp(k*C + 63, 2, 1'b0);
      push_exp(k*C + 0, 0, k == 2);
    end
    run_op("op6");
    check("finish_count_6", AW'(n_finish), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
